// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer
// Drives a byte-wide ALU one byte at a time (LSB first) to carry out a
// single NBYTES-wide ADD, ORR, XOR_B, AND or CMP operation. ADD spends two
// ALU cycles per byte (operand sum, then carry-in) and tracks the
// inter-byte carry locally.

module alu_word_sequencer #(
   parameter int NBYTES = 4,
   parameter int OPW    = 5
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [OPW-1:0]        Op,
   input  logic [8*NBYTES-1:0]   OperandA,
   input  logic [8*NBYTES-1:0]   OperandB,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Err,
   output logic [8*NBYTES-1:0]   Result,
   output logic                  CarryOut,
   output logic                  ZeroAll,
   output logic [7:0]            AluA,
   output logic [7:0]            AluB,
   output logic [OPW-1:0]        AluOp,
   input  logic [7:0]            AluOut,
   input  logic                  AluZero
);

   localparam int WW = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   localparam logic [OPW-1:0] OP_ORR   = OPW'(0);
   localparam logic [OPW-1:0] OP_XOR_B = OPW'(2);
   localparam logic [OPW-1:0] OP_AND   = OPW'(4);
   localparam logic [OPW-1:0] OP_CMP   = OPW'(12);
   localparam logic [OPW-1:0] OP_ADD   = OPW'(16);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_ADDC,
      S_ERR,
      S_DONE
   } stateT;

   stateT          state;
   stateT          nextState;

   logic [OPW-1:0] opReg;
   logic [WW-1:0]  aReg;
   logic [WW-1:0]  bReg;
   logic [WW-1:0]  accReg;
   logic [IW-1:0]  byteIdx;
   logic [7:0]     sumReg;
   logic           carry;
   logic           eqReg;

   logic [7:0]     aByte;
   logic [7:0]     bByte;
   logic           lastByte;
   logic           opLegal;
   logic           carryNext;
   logic           eqNext;
   logic [WW-1:0]  wordNext;
   logic [WW-1:0]  finalWord;
   logic           unusedZero;

   // The ALU Zero flag is redundant here: zero detection is done on the
   // assembled word so that it also covers the two-step ADD bytes.
   assign unusedZero = AluZero;

   assign aByte    = aReg[8*byteIdx +: 8];
   assign bByte    = bReg[8*byteIdx +: 8];
   assign lastByte = (byteIdx == LAST_IDX);
   assign opLegal  = (Op == OP_ORR) || (Op == OP_XOR_B) || (Op == OP_AND) ||
                     (Op == OP_CMP) || (Op == OP_ADD);

   assign Busy = (state != S_IDLE);
   assign Done = (state == S_DONE) || (state == S_ERR);
   assign Err  = (state == S_ERR);

   // State register; reset aborts any operation in flight.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic and ALU drive, both derived from registered state only.
   always_comb begin
      nextState = state;
      AluA      = '0;
      AluB      = '0;
      AluOp     = OP_ORR;
      case (state)
         S_IDLE: begin
            if (Start) begin
               nextState = opLegal ? S_ISSUE : S_ERR;
            end
         end
         S_ISSUE: begin
            AluA  = aByte;
            AluB  = bByte;
            AluOp = opReg;
            if (opReg == OP_ADD) begin
               nextState = S_ADDC;
            end else begin
               nextState = lastByte ? S_DONE : S_ISSUE;
            end
         end
         S_ADDC: begin
            AluA      = sumReg;
            AluB      = {7'b0, carry};
            AluOp     = OP_ADD;
            nextState = lastByte ? S_DONE : S_ISSUE;
         end
         S_ERR:   nextState = S_IDLE;
         S_DONE:  nextState = S_IDLE;
         default: nextState = S_IDLE;
      endcase
   end

   // Per-byte merge of the ALU answer into the word, CMP fold and ADD carry.
   always_comb begin
      wordNext                   = accReg;
      wordNext[8*byteIdx +: 8]   = AluOut;
      eqNext                     = eqReg & AluOut[0];
      carryNext                  = (sumReg < aByte) | (AluOut < sumReg);
      finalWord                  = (opReg == OP_CMP) ? {{(WW-1){1'b0}}, eqNext}
                                                     : wordNext;
   end

   // Operand capture, byte stepping and the completion update of the
   // visible result flags, which land on the edge that enters DONE.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         opReg    <= OP_ORR;
         aReg     <= '0;
         bReg     <= '0;
         accReg   <= '0;
         byteIdx  <= '0;
         sumReg   <= '0;
         carry    <= 1'b0;
         eqReg    <= 1'b1;
         Result   <= '0;
         CarryOut <= 1'b0;
         ZeroAll  <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (Start) begin
                  opReg   <= Op;
                  aReg    <= OperandA;
                  bReg    <= OperandB;
                  accReg  <= '0;
                  byteIdx <= '0;
                  carry   <= 1'b0;
                  eqReg   <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (opReg == OP_ADD) begin
                  sumReg <= AluOut;
               end else begin
                  accReg <= wordNext;
                  eqReg  <= eqNext;
                  if (lastByte) begin
                     Result   <= finalWord;
                     CarryOut <= 1'b0;
                     ZeroAll  <= (finalWord == '0);
                  end else begin
                     byteIdx <= byteIdx + 1'b1;
                  end
               end
            end
            S_ADDC: begin
               accReg <= wordNext;
               carry  <= carryNext;
               if (lastByte) begin
                  Result   <= wordNext;
                  CarryOut <= carryNext;
                  ZeroAll  <= (wordNext == '0);
               end else begin
                  byteIdx <= byteIdx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// tb_alu_word_sequencer
// Table-driven directed vectors plus randomized operations for
// alu_word_sequencer (NBYTES=4), with a byte-wide ALU model attached and a
// word-level reference model for expected results and latencies.

module tb_alu_word_sequencer;

   localparam int NBYTES = 4;
   localparam int WW     = 8 * NBYTES;
   localparam int OPW    = 5;

   logic              Clk = 1'b0;
   logic              Reset;
   logic              Start;
   logic [OPW-1:0]    Op;
   logic [WW-1:0]     OperandA;
   logic [WW-1:0]     OperandB;
   logic              Busy;
   logic              Done;
   logic              Err;
   logic [WW-1:0]     Result;
   logic              CarryOut;
   logic              ZeroAll;
   logic [7:0]        AluA;
   logic [7:0]        AluB;
   logic [OPW-1:0]    AluOp;
   logic [7:0]        AluOut;
   logic              AluZero;

   int vecCount  = 0;
   int missCount = 0;

   logic [WW-1:0] lastRes;
   logic          lastCarry;
   logic          lastZero;

   typedef struct {
      logic [OPW-1:0] op;
      logic [WW-1:0]  a;
      logic [WW-1:0]  b;
      logic [WW-1:0]  res;
      logic           carry;
      logic           zero;
      int             lat;
      logic           err;
      logic           pulse;
   } vecT;

   vecT vecs[11];

   alu_word_sequencer #(.NBYTES(NBYTES), .OPW(OPW)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .Op       (Op),
      .OperandA (OperandA),
      .OperandB (OperandB),
      .Busy     (Busy),
      .Done     (Done),
      .Err      (Err),
      .Result   (Result),
      .CarryOut (CarryOut),
      .ZeroAll  (ZeroAll),
      .AluA     (AluA),
      .AluB     (AluB),
      .AluOp    (AluOp),
      .AluOut   (AluOut),
      .AluZero  (AluZero)
   );

   // Free-running clock.
   always #5 Clk = ~Clk;

   // Byte-wide ALU model: combinational Out and Zero.
   always_comb begin
      AluOut = 8'h00;
      case (AluOp)
         5'd0:    AluOut = AluA | AluB;
         5'd2:    AluOut = AluA ^ AluB;
         5'd4:    AluOut = AluA & AluB;
         5'd12:   AluOut = {7'b0, (AluA == AluB)};
         5'd16:   AluOut = AluA + AluB;
         default: AluOut = 8'h00;
      endcase
      AluZero = (AluOut == 8'h00);
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " Busy"},     64'(Busy),     64'd0);
      checkOutput({tag, " Done"},     64'(Done),     64'd0);
      checkOutput({tag, " Err"},      64'(Err),      64'd0);
      checkOutput({tag, " Result"},   64'(Result),   64'd0);
      checkOutput({tag, " CarryOut"}, 64'(CarryOut), 64'd0);
      checkOutput({tag, " ZeroAll"},  64'(ZeroAll),  64'd1);
      checkOutput({tag, " AluABOp"},  64'({AluA, AluB, AluOp}), 64'd0);
   endtask

   // Word-level reference: whole-word arithmetic, latency by op class.
   task automatic refModel(input logic [OPW-1:0] op, input logic [WW-1:0] a,
                           input logic [WW-1:0] b, output logic [WW-1:0] res,
                           output logic carry, output logic zero,
                           output int lat, output logic err);
      logic [WW:0] wide;
      err   = 1'b0;
      carry = 1'b0;
      lat   = NBYTES + 1;
      res   = '0;
      case (op)
         5'd0:  res = a | b;
         5'd2:  res = a ^ b;
         5'd4:  res = a & b;
         5'd12: res = (a == b) ? WW'(1) : WW'(0);
         5'd16: begin
            wide  = {1'b0, a} + {1'b0, b};
            res   = wide[WW-1:0];
            carry = wide[WW];
            lat   = 2 * NBYTES + 1;
         end
         default: begin
            res   = lastRes;
            carry = lastCarry;
            err   = 1'b1;
            lat   = 1;
         end
      endcase
      zero = (op inside {5'd0, 5'd2, 5'd4, 5'd12, 5'd16}) ? (res == '0) : lastZero;
   endtask

   // Issue one operation and check latency, Busy span, flags and result.
   task automatic applyStimulus(input logic [OPW-1:0] op, input logic [WW-1:0] a,
                                input logic [WW-1:0] b, input logic pulse,
                                input logic [WW-1:0] expRes, input logic expCarry,
                                input logic expZero, input int expLat,
                                input logic expErr);
      int   cyc;
      logic busyOk;
      @(negedge Clk);
      Start    = 1'b1;
      Op       = op;
      OperandA = a;
      OperandB = b;
      @(posedge Clk);
      #1;
      if (pulse) begin
         Start    = 1'b1;
         Op       = 5'd16;
         OperandA = $urandom;
         OperandB = $urandom;
      end else begin
         Start = 1'b0;
      end
      cyc    = 1;
      busyOk = 1'b1;
      while (Done !== 1'b1 && cyc < 40) begin
         if (Busy !== 1'b1) busyOk = 1'b0;
         @(posedge Clk);
         #1;
         Start = 1'b0;
         cyc++;
      end
      if (Busy !== 1'b1) busyOk = 1'b0;
      checkOutput($sformatf("op%0d latency", op), 64'(cyc), 64'(expLat));
      checkOutput($sformatf("op%0d busy span", op), 64'(busyOk), 64'd1);
      checkOutput($sformatf("op%0d Err", op), 64'(Err), 64'(expErr));
      checkOutput($sformatf("op%0d Result", op), 64'(Result), 64'(expRes));
      checkOutput($sformatf("op%0d CarryOut", op), 64'(CarryOut), 64'(expCarry));
      checkOutput($sformatf("op%0d ZeroAll", op), 64'(ZeroAll), 64'(expZero));
      @(posedge Clk);
      #1;
      Start = 1'b0;
      checkOutput($sformatf("op%0d idle after done", op),
                  64'({Busy, Done, AluA, AluB, AluOp}), 64'd0);
      lastRes   = expRes;
      lastCarry = expCarry;
      lastZero  = expZero;
   endtask

   initial begin
      logic [OPW-1:0] rop;
      logic [WW-1:0]  ra;
      logic [WW-1:0]  rb;
      logic [WW-1:0]  eRes;
      logic           eCarry;
      logic           eZero;
      logic           eErr;
      int             eLat;
      logic [OPW-1:0] legalOps[5]   = '{5'd0, 5'd2, 5'd4, 5'd12, 5'd16};
      logic [OPW-1:0] illegalOps[5] = '{5'd1, 5'd3, 5'd14, 5'd17, 5'd31};

      vecs[0]  = '{5'd16, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 9, 1'b0, 1'b0};
      vecs[1]  = '{5'd16, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 9, 1'b0, 1'b0};
      vecs[2]  = '{5'd4,  32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 1'b0, 1'b0, 5, 1'b0, 1'b0};
      vecs[3]  = '{5'd2,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0, 5, 1'b0, 1'b0};
      vecs[4]  = '{5'd12, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000001, 1'b0, 1'b0, 5, 1'b0, 1'b0};
      vecs[5]  = '{5'd14, 32'h12345678, 32'h9ABCDEF0, 32'h00000001, 1'b0, 1'b0, 1, 1'b1, 1'b1};
      vecs[6]  = '{5'd12, 32'hDEADBEEF, 32'h5EADBEEF, 32'h00000000, 1'b0, 1'b1, 5, 1'b0, 1'b0};
      vecs[7]  = '{5'd0,  32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 5, 1'b0, 1'b1};
      vecs[8]  = '{5'd16, 32'h80808080, 32'h80808080, 32'h01010100, 1'b1, 1'b0, 9, 1'b0, 1'b1};
      vecs[9]  = '{5'd31, 32'h00000000, 32'h00000000, 32'h01010100, 1'b1, 1'b0, 1, 1'b1, 1'b0};
      vecs[10] = '{5'd12, 32'h00000000, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 5, 1'b0, 1'b0};

      Reset     = 1'b1;
      Start     = 1'b0;
      Op        = '0;
      OperandA  = '0;
      OperandB  = '0;
      lastRes   = '0;
      lastCarry = 1'b0;
      lastZero  = 1'b1;
      #12;
      checkResetValues("reset");
      @(negedge Clk);
      Reset = 1'b0;
      @(posedge Clk);
      #1;
      checkResetValues("idle");

      $display("[TB] directed vectors");
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pulse,
                       vecs[i].res, vecs[i].carry, vecs[i].zero,
                       vecs[i].lat, vecs[i].err);
      end

      $display("[TB] randomized vectors");
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            rop = illegalOps[$urandom_range(0, 4)];
         end else begin
            rop = legalOps[$urandom_range(0, 4)];
         end
         ra = $urandom;
         rb = ($urandom_range(0, 1) == 1) ? ra : 32'($urandom);
         refModel(rop, ra, rb, eRes, eCarry, eZero, eLat, eErr);
         applyStimulus(rop, ra, rb, 1'($urandom_range(0, 1)),
                       eRes, eCarry, eZero, eLat, eErr);
      end

      $display("[TB] reset during ADD byte 2");
      @(negedge Clk);
      Start    = 1'b1;
      Op       = 5'd16;
      OperandA = 32'h44FF8001;
      OperandB = 32'h33028002;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      repeat (4) begin
         @(posedge Clk);
         #1;
      end
      checkOutput("issue byte2 AluA", 64'(AluA), 64'hFF);
      checkOutput("issue byte2 AluB", 64'(AluB), 64'h02);
      checkOutput("issue byte2 AluOp", 64'(AluOp), 64'd16);
      @(posedge Clk);
      #1;
      checkOutput("addc byte2 AluA", 64'(AluA), 64'h01);
      checkOutput("addc byte2 AluB", 64'(AluB), 64'h01);
      checkOutput("addc byte2 AluOp", 64'(AluOp), 64'd16);
      Reset = 1'b1;
      #1;
      checkResetValues("midop reset");
      @(posedge Clk);
      #1;
      checkOutput("no done in reset", 64'({Done, Busy}), 64'd0);
      @(negedge Clk);
      Reset     = 1'b0;
      lastRes   = '0;
      lastCarry = 1'b0;
      lastZero  = 1'b1;
      applyStimulus(5'd16, 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 9, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
